// File: rtl/up_batch_processor_set.sv
// Minibatch weight/bias update: accumulates eta-scaled deltas over 2^batch_log2
// samples, then applies the averaged update with saturation and holds it for output.

module up_batch_lane #(
    parameter int fi        = 4,
    parameter int width     = 16,
    parameter int int_bits  = 5,
    parameter int frac_bits = 10
) (
    input  logic [width-1:0]          delta,
    input  logic [width-1:0]          eta,
    input  logic [fi-1:0][width-1:0]  act,
    output logic [width-1:0]          db,
    output logic [fi-1:0][width-1:0]  dw
);
    localparam logic signed [2*width-1:0] MAXP = {{(2*width-int_bits-frac_bits){1'b0}}, {(int_bits+frac_bits){1'b1}}};
    localparam logic signed [2*width-1:0] MINP = {{(2*width-int_bits-frac_bits){1'b1}}, {(int_bits+frac_bits){1'b0}}};

    // Full-width product, floor shift, clamp back to one word.
    function automatic logic [width-1:0] sat_mul(input logic [width-1:0] x, input logic [width-1:0] y);
        logic signed [2*width-1:0] xe, ye, p;
        xe = (2*width)'($signed(x));
        ye = (2*width)'($signed(y));
        p  = xe * ye;
        p  = p >>> frac_bits;
        if (p > MAXP)      return MAXP[width-1:0];
        else if (p < MINP) return MINP[width-1:0];
        else               return p[width-1:0];
    endfunction

    always_comb begin
        db = sat_mul(delta, eta);
        for (int j = 0; j < fi; j++) dw[j] = sat_mul(db, act[j]);
    end
endmodule

module up_batch_processor_set #(
    parameter int fi         = 4,
    parameter int z          = 8,
    parameter int width      = 16,
    parameter int int_bits   = 5,
    parameter int frac_bits  = 10,
    parameter int batch_log2 = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [width-1:0]        eta,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [width*z/fi-1:0]   delta_package,
    input  logic [width*z-1:0]      a_package,
    input  logic [width*z-1:0]      w_package,
    input  logic [width*z/fi-1:0]   b_package,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [width*z-1:0]      w_UP_package,
    output logic [width*z/fi-1:0]   b_UP_package
);
    localparam int nn        = z / fi;
    localparam int acc_width = width + batch_log2;
    localparam int cw        = (batch_log2 > 0) ? batch_log2 : 1;
    localparam logic [cw-1:0] LAST_CNT = cw'((1 << batch_log2) - 1);
    localparam logic signed [acc_width:0] SMAX = {{(acc_width+1-int_bits-frac_bits){1'b0}}, {(int_bits+frac_bits){1'b1}}};
    localparam logic signed [acc_width:0] SMIN = {{(acc_width+1-int_bits-frac_bits){1'b1}}, {(int_bits+frac_bits){1'b0}}};

    typedef enum logic [1:0] {ACCUM, APPLY, HOLD} state_t;

    state_t                           state_q, state_d;
    logic [cw-1:0]                    cnt_q, cnt_d;
    logic [z-1:0][acc_width-1:0]      acc_w_q, acc_w_d;
    logic [nn-1:0][acc_width-1:0]     acc_b_q, acc_b_d;
    logic [z-1:0][width-1:0]          w_cap_q, w_cap_d, w_up_q, w_up_d;
    logic [nn-1:0][width-1:0]         b_cap_q, b_cap_d, b_up_q, b_up_d;
    logic                             out_valid_q, out_valid_d;
    logic [nn-1:0][width-1:0]         db;
    logic [z-1:0][width-1:0]          dw;

    for (genvar i = 0; i < nn; i++) begin : g_lane
        up_batch_lane #(.fi(fi), .width(width), .int_bits(int_bits), .frac_bits(frac_bits)) u_lane (
            .delta (delta_package[i*width +: width]),
            .eta   (eta),
            .act   (a_package[i*fi*width +: fi*width]),
            .db    (db[i]),
            .dw    (dw[i*fi +: fi])
        );
    end

    // Batch average is a floor shift of the sum; the add is done one bit wider, then clamped.
    function automatic logic [width-1:0] sat_upd(input logic [width-1:0] cur, input logic [acc_width-1:0] acc);
        logic signed [acc_width:0] c_ext, a_ext, s;
        c_ext = (acc_width+1)'($signed(cur));
        a_ext = (acc_width+1)'($signed(acc));
        a_ext = a_ext >>> batch_log2;
        s     = c_ext + a_ext;
        if (s > SMAX)      return SMAX[width-1:0];
        else if (s < SMIN) return SMIN[width-1:0];
        else               return s[width-1:0];
    endfunction

    assign in_ready = (state_q == ACCUM) && reset_n;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_w_d = acc_w_q;
        acc_b_d = acc_b_q;
        w_cap_d = w_cap_q;
        b_cap_d = b_cap_q;
        w_up_d  = w_up_q;
        b_up_d  = b_up_q;
        case (state_q)
            ACCUM: if (in_valid && in_ready) begin
                for (int k = 0; k < z; k++)  acc_w_d[k] = acc_w_q[k] + acc_width'($signed(dw[k]));
                for (int i = 0; i < nn; i++) acc_b_d[i] = acc_b_q[i] + acc_width'($signed(db[i]));
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    w_cap_d = w_package;
                    b_cap_d = b_package;
                    state_d = APPLY;
                end else begin
                    cnt_d = cnt_q + cw'(1);
                end
            end
            APPLY: begin
                for (int k = 0; k < z; k++)  w_up_d[k] = sat_upd(w_cap_q[k], acc_w_q[k]);
                for (int i = 0; i < nn; i++) b_up_d[i] = sat_upd(b_cap_q[i], acc_b_q[i]);
                state_d = HOLD;
            end
            HOLD: if (out_ready) begin
                acc_w_d = '0;
                acc_b_d = '0;
                state_d = ACCUM;
            end
            default: state_d = ACCUM;
        endcase
        out_valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ACCUM;
            cnt_q       <= '0;
            acc_w_q     <= '0;
            acc_b_q     <= '0;
            w_cap_q     <= '0;
            b_cap_q     <= '0;
            w_up_q      <= '0;
            b_up_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_w_q     <= acc_w_d;
            acc_b_q     <= acc_b_d;
            w_cap_q     <= w_cap_d;
            b_cap_q     <= b_cap_d;
            w_up_q      <= w_up_d;
            b_up_q      <= b_up_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign w_UP_package = w_up_q;
    assign b_UP_package = b_up_q;
endmodule

// File: tb/tb_up_batch_processor_set.sv
// Scoreboard bench for up_batch_processor_set (batch of 4, Q5.10).

module tb_up_batch_processor_set;
    localparam int W  = 16;
    localparam int Z  = 8;
    localparam int NN = 2;

    logic            clk;
    logic            reset_n;
    logic [W-1:0]    eta;
    logic            in_valid, in_ready;
    logic [W*NN-1:0] delta_package, b_package, b_UP_package;
    logic [W*Z-1:0]  a_package, w_package, w_UP_package;
    logic            out_valid, out_ready;

    typedef struct packed {
        logic [W*Z-1:0]  w;
        logic [W*NN-1:0] b;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    up_batch_processor_set dut (
        .clk(clk), .reset_n(reset_n), .eta(eta),
        .in_valid(in_valid), .in_ready(in_ready),
        .delta_package(delta_package), .a_package(a_package),
        .w_package(w_package), .b_package(b_package),
        .out_valid(out_valid), .out_ready(out_ready),
        .w_UP_package(w_UP_package), .b_UP_package(b_UP_package)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic logic [W*Z-1:0] rw(input logic [W-1:0] v);
        return {Z{v}};
    endfunction

    function automatic logic [W*NN-1:0] rb(input logic [W-1:0] v);
        return {NN{v}};
    endfunction

    // Monitor: every output handshake must match the oldest expected result.
    always @(negedge clk) begin
        exp_t e;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_output: got w=%h, expected no output", w_UP_package);
            end else begin
                e = exp_q.pop_front();
                chk("w_UP", w_UP_package, 128'(e.w));
                chk("b_UP", 128'(b_UP_package), 128'(e.b));
            end
        end
    end

    // Four back-to-back samples; w/b carry junk except on the last one.
    task automatic run_batch(input logic [W*NN-1:0] d, input logic [W-1:0] e,
                             input logic [W*Z-1:0] a, input logic [W*Z-1:0] a_last,
                             input logic [W*Z-1:0] w, input logic [W*NN-1:0] b,
                             input logic [W*Z-1:0] ew, input logic [W*NN-1:0] eb,
                             input bit push);
        for (int s = 0; s < 4; s++) begin
            in_valid      = 1'b1;
            delta_package = d;
            eta           = e;
            a_package     = (s == 3) ? a_last : a;
            w_package     = (s == 3) ? w : rw(16'hDEAD);
            b_package     = (s == 3) ? b : rb(16'hBEEF);
            if (s == 3 && push) exp_q.push_back('{w: ew, b: eb});
            #1 chk("in_ready_accum", 128'(in_ready), 128'(1));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("in_ready_apply", 128'(in_ready), 128'(0));
        chk("out_valid_apply", 128'(out_valid), 128'(0));
        @(posedge clk); #1;
        chk("out_valid_hold", 128'(out_valid), 128'(1));
        if (out_ready) begin
            @(posedge clk); #1;
            chk("out_valid_pulse", 128'(out_valid), 128'(0));
            chk("in_ready_after_hs", 128'(in_ready), 128'(1));
        end
    endtask

    task automatic basic_batch();
        run_batch(rb(16'h0400), 16'hFFCD, rw(16'h0800), rw(16'h0800), rw(16'h0500), rb(16'h0400),
                  rw(16'h049A), rb(16'h03CD), 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; eta = '0;
        delta_package = '0; a_package = '0; w_package = '0; b_package = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_w_UP", w_UP_package, 128'(0));
        chk("rst_b_UP", 128'(b_UP_package), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        reset_n = 1'b1;
        #1 chk("in_ready_after_rst", 128'(in_ready), 128'(1));

        // -51/1024*2 = -102 per sample; mean -102
        basic_batch();
        // last sample a=0x0801 gives dw=-103: sum -409 floors to -103
        run_batch(rb(16'h0400), 16'hFFCD, rw(16'h0800), rw(16'h0801), rw(16'h0500), rb(16'h0400),
                  rw(16'h0499), rb(16'h03CD), 1'b1);
        // neuron 1 delta 0, weight 1 activation 0
        run_batch({16'h0000, 16'h0400}, 16'hFFCD,
                  {16'h0800, 16'h0800, 16'h0800, 16'h0800, 16'h0800, 16'h0800, 16'h0000, 16'h0800},
                  {16'h0800, 16'h0800, 16'h0800, 16'h0800, 16'h0800, 16'h0800, 16'h0000, 16'h0800},
                  rw(16'h0500), rb(16'h0400),
                  {16'h0500, 16'h0500, 16'h0500, 16'h0500, 16'h049A, 16'h049A, 16'h0500, 16'h049A},
                  {16'h0400, 16'h03CD}, 1'b1);
        // positive weight saturation
        run_batch(rb(16'h0400), 16'h0400, rw(16'h7FFF), rw(16'h7FFF), rw(16'h7F00), rb(16'h0000),
                  rw(16'h7FFF), rb(16'h0400), 1'b1);
        // db saturates to 0x7FFF
        run_batch(rb(16'h7FFF), 16'h7FFF, rw(16'h0000), rw(16'h0000), rw(16'h1234), rb(16'h0100),
                  rw(16'h1234), rb(16'h7FFF), 1'b1);
        // negative saturation at the accumulator's minimum
        run_batch(rb(16'h7FFF), 16'h8000, rw(16'h0400), rw(16'h0400), rw(16'h8100), rb(16'h8100),
                  rw(16'h8000), rb(16'h8000), 1'b1);

        // backpressure: HOLD for 5 cycles while junk is offered
        out_ready = 1'b0;
        basic_batch();
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; delta_package = rb(16'h7FFF); eta = 16'h7FFF; a_package = rw(16'h7FFF);
            @(posedge clk); #1;
            chk("bp_out_valid", 128'(out_valid), 128'(1));
            chk("bp_in_ready", 128'(in_ready), 128'(0));
            chk("bp_w_stable", w_UP_package, 128'(rw(16'h049A)));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", 128'(out_valid), 128'(0));
        chk("bp_release_ready", 128'(in_ready), 128'(1));
        basic_batch();

        // reset after two samples
        for (int s = 0; s < 2; s++) begin
            in_valid = 1'b1; delta_package = rb(16'h0400); eta = 16'h0400; a_package = rw(16'h7FFF);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        reset_n = 1'b0;
        #1 chk("mid_rst_in_ready", 128'(in_ready), 128'(0));
        @(posedge clk); #1;
        chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
        chk("mid_rst_w_UP", w_UP_package, 128'(0));
        chk("mid_rst_b_UP", 128'(b_UP_package), 128'(0));
        reset_n = 1'b1;
        basic_batch();

        // reset while HOLD: pending result dropped
        out_ready = 1'b0;
        run_batch(rb(16'h0400), 16'hFFCD, rw(16'h0800), rw(16'h0800), rw(16'h0500), rb(16'h0400),
                  rw(16'h049A), rb(16'h03CD), 1'b0);
        reset_n = 1'b0;
        @(posedge clk); #1;
        chk("hold_rst_out_valid", 128'(out_valid), 128'(0));
        chk("hold_rst_w_UP", w_UP_package, 128'(0));
        chk("hold_rst_in_ready", 128'(in_ready), 128'(0));
        reset_n = 1'b1;
        #1 chk("hold_rst_in_ready_rel", 128'(in_ready), 128'(1));
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("hold_rst_no_output", 128'(out_valid), 128'(0));
        basic_batch();

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
